// File: rtl/tslice_job_arbiter.sv
// tslice_job_arbiter
// Round-robin arbiter that hands one tensor-slice matmul engine to one of
// NUM_REQ requesters at a time and drives the engine's ap_ctrl_chain
// handshake (ap_start/ap_ready, ap_done/ap_continue) on their behalf.
//
// Optional build macro: TSLICE_ARB_TIMEOUT_EN
//   defined   -> RUN-state watchdog; after TIMEOUT_CYCLES without ap_done the
//                job is force-completed and timeout_err latches until reset.
//   undefined -> no watchdog, timeout_err tied low, RUN waits indefinitely.
//
// state | meaning
// IDLE  | engine free; round-robin pick among asserted req
// START | grant held, eng_ap_start high until eng_ap_ready
// RUN   | engine working, waiting for eng_ap_done (or watchdog)
// ACK   | done_pulse/eng_ap_continue visible; grant released next edge

module tslice_job_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic [NUM_REQ-1:0] done_pulse,
  output logic               eng_ap_start,
  input  logic               eng_ap_ready,
  input  logic               eng_ap_done,
  output logic               eng_ap_continue,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // Elaboration-time guard on the supported parameter range
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tslice_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic [ID_W-1:0]    r_last_id;
  logic [NUM_REQ-1:0] r_done_pulse;
  logic               r_start;
  logic               r_continue;
  logic               r_busy;

  logic               w_found;
  logic [ID_W-1:0]    w_pick_id;
  logic [ID_W-1:0]    w_cand;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic               w_wd_expire;

  // Round-robin search: first asserted req starting just after last winner
  always_comb begin
    w_found   = 1'b0;
    w_pick_id = '0;
    w_cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = ID_W'((int'(r_last_id) + i) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found   = 1'b1;
        w_pick_id = w_cand;
      end
    end
  end

  assign w_pick_oh = NUM_REQ'(1) << w_pick_id;

`ifdef TSLICE_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;

  // Expiry is the terminal count seen while still in RUN
  assign w_wd_expire = (r_state == S_RUN) && (r_wd_cnt == '0);

  // Watchdog down-counter, loaded on RUN entry; sticky error on expiry
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_START && eng_ap_ready) begin
        r_wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      end else if (r_state == S_RUN && r_wd_cnt != '0) begin
        r_wd_cnt <= r_wd_cnt - WD_W'(1);
      end
      // A real done on the terminal cycle wins; no error in that case
      if (w_wd_expire && !eng_ap_done) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_wd_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main job FSM; every output comes straight from a register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_gnt_id     <= '0;
      r_last_id    <= ID_W'(NUM_REQ - 1);
      r_done_pulse <= '0;
      r_start      <= 1'b0;
      r_continue   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done_pulse <= '0;
      r_continue   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt    <= w_pick_oh;
            r_gnt_id <= w_pick_id;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          // Once the engine has taken the start, the job is committed
          if (eng_ap_ready) begin
            r_start <= 1'b0;
            if (eng_ap_done) begin
              r_done_pulse <= r_gnt;
              r_continue   <= 1'b1;
              r_state      <= S_ACK;
            end else begin
              r_state <= S_RUN;
            end
          end else if (!req[r_gnt_id]) begin
            // Requester gave up before the engine accepted: quiet abort
            r_start  <= 1'b0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          if (eng_ap_done || w_wd_expire) begin
            r_done_pulse <= r_gnt;
            r_continue   <= 1'b1;
            r_state      <= S_ACK;
          end
        end
        S_ACK: begin
          r_last_id <= r_gnt_id;
          r_gnt     <= '0;
          r_gnt_id  <= '0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_gnt    <= '0;
          r_gnt_id <= '0;
          r_start  <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt             = r_gnt;
  assign gnt_id          = r_gnt_id;
  assign done_pulse      = r_done_pulse;
  assign eng_ap_start    = r_start;
  assign eng_ap_continue = r_continue;
  assign busy            = r_busy;

endmodule

// File: doc/tslice_job_arbiter.md
TSLICE_JOB_ARBITER -- requirements
Module: tslice_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one tensor-slice matmul engine (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: RUN-state watchdog limit, in cycles.
REQ-003 ap_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 ap_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester job request, level; held until own done_pulse.
REQ-006 gnt  output  NUM_REQ  one-hot grant to the requester owning the engine.
REQ-007 gnt_id  output  $clog2(NUM_REQ)  binary index of the granted requester.
REQ-008 done_pulse  output  NUM_REQ  one-cycle completion strobe to the granted requester.
REQ-009 eng_ap_start  output  1  engine start (ap_ctrl_chain).
REQ-010 eng_ap_ready  input  1  engine accepted start.
REQ-011 eng_ap_done  input  1  engine result complete.
REQ-012 eng_ap_continue  output  1  engine done acknowledge.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 timeout_err  output  1  sticky watchdog error flag (see Configuration).

Function
REQ-015 States SHALL be IDLE, START, RUN, ACK; all outputs registered.
REQ-016 IDLE: if |req, SHALL pick the first asserted req searching from last_id+1 mod NUM_REQ (round-robin), load gnt/gnt_id, assert eng_ap_start, go to START on the next edge (1-cycle req-to-start latency).
REQ-017 START: eng_ap_start SHALL stay high until eng_ap_ready is sampled high, then drop on that edge; go to RUN.
REQ-018 START with req[gnt_id] withdrawn before eng_ap_ready: SHALL drop eng_ap_start and gnt, go to IDLE, leave last_id unchanged, no done_pulse.
REQ-019 RUN: on eng_ap_done high, SHALL assert eng_ap_continue and done_pulse[gnt_id] for exactly one cycle, go to ACK.
REQ-020 req withdrawn during RUN SHALL NOT abort the job; done_pulse still issued.
REQ-021 ACK: SHALL clear gnt, set last_id <= gnt_id, return to IDLE; guarantees ≥1 idle cycle between jobs.
REQ-022 eng_ap_ready and eng_ap_done high in the same START cycle SHALL go directly to ACK with the REQ-019 pulses.
REQ-023 gnt SHALL be zero or one-hot at all times; done_pulse only to the granted bit.
REQ-024 No requester SHALL wait longer than NUM_REQ-1 jobs once its req is asserted.

Reset
REQ-025 ap_rst_n low SHALL immediately force IDLE, gnt=0, gnt_id=0, done_pulse=0, eng_ap_start=0, eng_ap_continue=0, busy=0, timeout_err=0, last_id=NUM_REQ-1 (first winner is requester 0), watchdog count=0.
REQ-026 Reset mid-job SHALL abandon the job silently; no done_pulse after deassertion.

Configuration
REQ-027 Macro TSLICE_ARB_TIMEOUT_EN defined: RUN counts cycles; at TIMEOUT_CYCLES without eng_ap_done, SHALL set timeout_err (sticky until reset), pulse done_pulse[gnt_id], assert eng_ap_continue one cycle, go to ACK.
REQ-028 Macro undefined: no counter, timeout_err tied 0, RUN waits indefinitely.

Verification
REQ-029 Reset, req=4'b0001, engine ready after 1 cycle, done after 20 -> gnt=0001, eng_ap_start high 1 cycle, done_pulse[0] one cycle, busy falls after ACK.
REQ-030 req=4'b1111 held, 8 jobs -> grant order 0,1,2,3,0,1,2,3; each job separated by one idle cycle.
REQ-031 req=4'b0100 withdrawn while in START (ready low) -> eng_ap_start drops, gnt=0, no done_pulse; next req=4'b0110 grants 1.
REQ-032 ready and done high same cycle -> START->ACK, single done_pulse, single eng_ap_continue.
REQ-033 TSLICE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> after 16 RUN cycles timeout_err=1, done_pulse fires, arbiter returns to IDLE; timeout_err clears only on ap_rst_n low.
REQ-034 ap_rst_n low during RUN with req=4'b0010 -> all outputs zero asynchronously; after release, requester 0 wins next if req[0] asserted.
